// File: rtl/fp_mul_hs.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_hs
// Brief    : Handshaked sequential floating-point multiplier (shift-add core)
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_hs #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int ROUND = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   startMul,
    input  logic                   resultAccept,
    input  logic [EXP_W+MAN_W:0]   dataIn,
    input  logic                   dataReady,
    output logic [EXP_W+MAN_W:0]   resultBus,
    output logic                   dataAccept,
    output logic                   doneMul,
    output logic                   resultReady,
    output logic [2:0]             flags
);

    localparam int c_W  = 1 + EXP_W + MAN_W;
    localparam int c_N  = MAN_W + 1;
    localparam int c_CW = $clog2(c_N);
    localparam int c_XW = EXP_W + 2;

    localparam logic [c_XW-1:0]  c_BIAS = c_XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W:0]   c_EMAX = (EXP_W + 1)'((1 << EXP_W) - 1);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(c_N - 1);
    localparam logic [c_W-1:0]   c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [2:0] S_LDA  = 3'd0;
    localparam logic [2:0] S_LDB  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MUL  = 3'd3;
    localparam logic [2:0] S_NORM = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    logic [2:0]       r_state;
    logic             r_arm;
    logic [c_W-1:0]   r_a;
    logic [c_W-1:0]   r_b;
    logic [2*c_N-1:0] r_prod;
    logic [c_CW-1:0]  r_cnt;

    // operand field decode
    logic             w_sign;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

    assign w_sign   = r_a[c_W-1] ^ r_b[c_W-1];
    assign w_ea     = r_a[c_W-2:MAN_W];
    assign w_eb     = r_b[c_W-2:MAN_W];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == '1) && (r_a[MAN_W-1:0] == '0);
    assign w_b_inf  = (w_eb == '1) && (r_b[MAN_W-1:0] == '0);
    assign w_a_nan  = (w_ea == '1) && (r_a[MAN_W-1:0] != '0);
    assign w_b_nan  = (w_eb == '1) && (r_b[MAN_W-1:0] != '0);

    // shift-add step: conditionally add multiplicand to upper half, shift right
    logic [c_N:0] w_sum;
    assign w_sum = {1'b0, r_prod[2*c_N-1:c_N]} + (r_prod[0] ? {2'b01, r_a[MAN_W-1:0]} : '0);

    // normalise / round
    logic             w_top, w_guard, w_sticky, w_inc, w_carry, w_ovf, w_unf;
    logic [c_N-1:0]   w_sig;
    logic [c_N:0]     w_sig_r;
    logic [MAN_W-1:0] w_man;
    logic [c_XW-1:0]  w_exp;
    logic [c_W-1:0]   w_res;
    logic [2:0]       w_flg;

    assign w_top    = r_prod[2*c_N-1];
    assign w_sig    = w_top ? r_prod[2*c_N-1:c_N] : r_prod[2*c_N-2:c_N-1];
    assign w_guard  = w_top ? r_prod[c_N-1] : r_prod[c_N-2];
    assign w_sticky = w_top ? (|r_prod[c_N-2:0]) : (|r_prod[c_N-3:0]);
    assign w_inc    = (ROUND == 1) && w_guard && (w_sticky || w_sig[0]);
    assign w_sig_r  = {1'b0, w_sig} + {{c_N{1'b0}}, w_inc};
    assign w_carry  = w_sig_r[c_N];
    assign w_man    = w_carry ? w_sig_r[MAN_W:1] : w_sig_r[MAN_W-1:0];
    assign w_exp    = {2'b00, w_ea} + {2'b00, w_eb} - c_BIAS
                    + {{(c_XW-1){1'b0}}, w_top} + {{(c_XW-1){1'b0}}, w_carry};
    // exponent is signed in EXP_W+2 bits: top bit set means negative
    assign w_ovf    = !w_exp[c_XW-1] && (w_exp[EXP_W:0] >= c_EMAX);
    assign w_unf    = w_exp[c_XW-1] || (w_exp == '0);

    always_comb begin
        w_res = {w_sign, w_exp[EXP_W-1:0], w_man};
        w_flg = {2'b00, w_guard | w_sticky};
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_res = c_QNAN;
            w_flg = 3'b000;
        end else if (w_a_inf || w_b_inf) begin
            w_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flg = 3'b000;
        end else if (w_a_zero || w_b_zero) begin
            w_res = {w_sign, {(c_W-1){1'b0}}};
            w_flg = 3'b000;
        end else if (w_ovf) begin
            w_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flg = 3'b100;
        end else if (w_unf) begin
            w_res = {w_sign, {(c_W-1){1'b0}}};
            w_flg = 3'b010;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LDA;
            r_arm       <= 1'b1;
            r_a         <= '0;
            r_b         <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            resultBus   <= '0;
            flags       <= 3'b000;
            dataAccept  <= 1'b0;
            doneMul     <= 1'b0;
            resultReady <= 1'b0;
        end else begin
            dataAccept <= 1'b0;
            doneMul    <= 1'b0;
            if (!dataReady) begin
                r_arm <= 1'b1;
            end
            case (r_state)
                S_LDA: begin
                    if (dataReady && r_arm) begin
                        r_a        <= dataIn;
                        dataAccept <= 1'b1;
                        r_arm      <= 1'b0;
                        r_state    <= S_LDB;
                    end
                end
                S_LDB: begin
                    if (dataReady && r_arm) begin
                        r_b        <= dataIn;
                        dataAccept <= 1'b1;
                        r_arm      <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (startMul) begin
                        r_prod  <= {{c_N{1'b0}}, 1'b1, r_b[MAN_W-1:0]};
                        r_cnt   <= '0;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_prod <= {w_sum, r_prod[c_N-1:1]};
                    if (r_cnt == c_LAST) begin
                        r_state <= S_NORM;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_NORM: begin
                    resultBus <= w_res;
                    flags     <= w_flg;
                    r_state   <= S_OUT;
                end
                S_OUT: begin
                    // first S_OUT cycle publishes; later cycles wait for the consumer
                    if (!resultReady) begin
                        resultReady <= 1'b1;
                        doneMul     <= 1'b1;
                    end else if (resultAccept) begin
                        resultReady <= 1'b0;
                        r_state     <= S_LDA;
                    end
                end
                default: begin
                    r_state <= S_LDA;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_hs
// Brief    : Self-checking bench for fp_mul_hs (truncating and RNE instances)
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_hs;

    logic        clk = 1'b0;
    logic        rst, startMul, resultAccept, dataReady;
    logic [31:0] dataIn;
    logic [31:0] rb0, rb1;
    logic [2:0]  fl0, fl1;
    logic        da0, da1, dm0, dm1, rr0, rr1;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [34:0] last0, last1;

    always #5 clk = ~clk;

    fp_mul_hs #(.EXP_W(8), .MAN_W(23), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .startMul(startMul), .resultAccept(resultAccept),
        .dataIn(dataIn), .dataReady(dataReady), .resultBus(rb0), .dataAccept(da0),
        .doneMul(dm0), .resultReady(rr0), .flags(fl0));

    fp_mul_hs #(.EXP_W(8), .MAN_W(23), .ROUND(1)) dut1 (
        .clk(clk), .rst(rst), .startMul(startMul), .resultAccept(resultAccept),
        .dataIn(dataIn), .dataReady(dataReady), .resultBus(rb1), .dataAccept(da1),
        .doneMul(dm1), .resultReady(rr1), .flags(fl1));

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product, then normalise/round by remainder vs half-ulp
    function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit rnd);
        int     ea = int'(a[30:23]);
        int     eb = int'(b[30:23]);
        longint ma = longint'(a[22:0]);
        longint mb = longint'(b[22:0]);
        bit     s  = a[31] ^ b[31];
        bit     an = (ea == 255) && (ma != 0);
        bit     bn = (eb == 255) && (mb != 0);
        bit     ai = (ea == 255) && (ma == 0);
        bit     bi = (eb == 255) && (mb == 0);
        bit     az = (ea == 0);
        bit     bz = (eb == 0);
        longint p, sig, rem, half;
        int     e, sh;
        bit     inx;
        if (an || bn || (ai && bz) || (bi && az)) return {3'b000, 32'h7FC00000};
        if (ai || bi) return {3'b000, s, 8'hFF, 23'd0};
        if (az || bz) return {3'b000, s, 31'd0};
        p = (ma + 64'd8388608) * (mb + 64'd8388608);
        e = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
        else sh = 23;
        sig  = p >> sh;
        rem  = p - (sig << sh);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
        if (rnd && ((rem > half) || ((rem == half) && sig[0]))) sig = sig + 1;
        if (sig == (64'd1 << 24)) begin sig = sig >> 1; e = e + 1; end
        if (e >= 255) return {3'b100, s, 8'hFF, 23'd0};
        if (e <= 0) return {3'b010, s, 31'd0};
        return {2'b00, inx, s, e[7:0], sig[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        case ($urandom_range(0, 9))
            0:       e = 8'd0;
            1:       e = 8'd255;
            2, 3:    e = 8'($urandom_range(200, 254));
            4, 5:    e = 8'($urandom_range(1, 60));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), e, ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom)};
    endfunction

    task automatic load(input logic [31:0] v, input string tag);
        dataIn = v; dataReady = 1'b1;
        @(posedge clk); #1;
        chk({tag, " accept"}, {da0, da1}, 2'b11);
        dataReady = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [34:0] e0, e1;
        int k;
        bit seen;
        e0 = ref_mul(a, b, 1'b0);
        e1 = ref_mul(a, b, 1'b1);
        startMul = 1'b1;
        @(posedge clk); #1;
        startMul = 1'b0;
        k = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (dm0) seen = 1'b1;
        end
        chk({tag, " latency"}, 72'(k), 72'd26);
        chk({tag, " ready"}, {dm1, rr0, rr1}, 3'b111);
        last0 = {fl0, rb0};
        last1 = {fl1, rb1};
        chk({tag, " trunc"}, last0, e0);
        chk({tag, " rne"}, last1, e1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " hold"}, {dm0, dm1, rr0, rr1, fl0, rb0, fl1, rb1}, {4'b0011, e0, e1});
        resultAccept = 1'b1;
        @(posedge clk); #1;
        resultAccept = 1'b0;
        chk({tag, " released"}, {rr0, rr1}, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [31:0] a, b;
        rst = 1'b1; startMul = 1'b0; resultAccept = 1'b0; dataReady = 1'b0; dataIn = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {rb0, fl0, da0, dm0, rr0, rb1, fl1, da1, dm1, rr1}, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        load(32'h41440000, "t34 A"); load(32'hC0600000, "t34 B");
        run_mul(32'h41440000, 32'hC0600000, "t34");
        chk("t34 const", last0, {3'b000, 32'hC22B8000});

        load(32'h40100000, "t35 A"); load(32'h418C0000, "t35 B");
        run_mul(32'h40100000, 32'h418C0000, "t35");
        chk("t35 const", last0, {3'b000, 32'h421D8000});

        load(32'h7F800000, "infxz A"); load(32'h00000000, "infxz B");
        run_mul(32'h7F800000, 32'h00000000, "infxz");
        chk("infxz const", last0, {3'b000, 32'h7FC00000});

        load(32'h7F000000, "ovf A"); load(32'h40000000, "ovf B");
        run_mul(32'h7F000000, 32'h40000000, "ovf");
        chk("ovf const", last0, {3'b100, 32'h7F800000});

        load(32'h3FC00001, "rnd A"); load(32'h3FC00000, "rnd B");
        run_mul(32'h3FC00001, 32'h3FC00000, "rnd");
        chk("rnd trunc const", last0, {3'b001, 32'h40100000});
        chk("rnd rne const", last1, {3'b001, 32'h40100001});

        // held dataReady loads only A; startMul in S_LDB is ignored
        a = 32'h40400000; b = 32'h40A00000;
        dataIn = a; dataReady = 1'b1; pulses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (da0) pulses++;
        end
        dataReady = 1'b0;
        chk("held ready pulses", 72'(pulses), 72'd1);
        @(posedge clk); #1;
        startMul = 1'b1;
        @(posedge clk); #1;
        startMul = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (dm0 || dm1) pulses++;
        end
        chk("ignored start", 72'(pulses), 72'd0);
        load(b, "held B");
        run_mul(a, b, "held");

        // reset during S_MUL
        load(32'h3F800001, "abort A"); load(32'h40490FDB, "abort B");
        startMul = 1'b1;
        @(posedge clk); #1;
        startMul = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort outputs", {rb0, fl0, da0, dm0, rr0, rb1, fl1, da1, dm1, rr1}, '0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (dm0 || dm1 || rr0 || rr1) pulses++;
        end
        chk("abort no done", 72'(pulses), 72'd0);
        load(32'hBF9D70A4, "post A"); load(32'h42F6E979, "post B");
        run_mul(32'hBF9D70A4, 32'h42F6E979, "post");

        for (int i = 0; i < 30; i++) begin
            a = rand_op(); b = rand_op();
            load(a, "rand A"); load(b, "rand B");
            run_mul(a, b, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_mul_hs.md
FP_MUL_HS -- requirements
Module: fp_mul_hs

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored mantissa field width.
REQ-003 Parameter ROUND, default 0, rounding mode: 0 = truncate toward zero, 1 = round-to-nearest-even.
REQ-004 Derived widths: W = 1+EXP_W+MAN_W (32 by default); BIAS = 2^(EXP_W-1)-1.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 startMul  input  1  starts multiplication of the loaded operands.
REQ-008 resultAccept  input  1  consumer takes resultBus.
REQ-009 dataIn  input  W  operand bus.
REQ-010 dataReady  input  1  producer has a valid operand on dataIn.
REQ-011 resultBus  output  W  product.
REQ-012 dataAccept  output  1  operand latched this cycle.
REQ-013 doneMul  output  1  one-cycle completion pulse.
REQ-014 resultReady  output  1  resultBus is valid and held.
REQ-015 flags  output  3  {overflow, underflow, inexact}, valid while resultReady=1.

Function
REQ-016 States: S_LDA, S_LDB, S_WAIT, S_MUL, S_NORM, S_OUT.
REQ-017 S_LDA/S_LDB: dataReady=1 with the arm bit set -> latch dataIn into A/B, dataAccept=1 for exactly that cycle, clear arm, advance (S_LDA->S_LDB->S_WAIT).
REQ-018 Arm bit is set whenever dataReady is sampled 0; a dataReady held high across cycles loads only one operand.
REQ-019 startMul is ignored outside S_WAIT; in S_WAIT, startMul=1 -> S_MUL.
REQ-020 S_MUL: radix-2 shift-add of the two (MAN_W+1)-bit significands (hidden bit restored), exactly MAN_W+1 cycles, then S_NORM.
REQ-021 S_NORM, one cycle: normalise the 2(MAN_W+1)-bit product (top bit set -> shift right 1, exponent+1), compute guard/sticky, round per ROUND, and renormalise on mantissa carry-out.
REQ-022 Result exponent = eA+eB-BIAS (+ normalisation/rounding increments), computed with EXP_W+2 signed bits; sign = sA XOR sB.
REQ-023 Fixed latency: doneMul pulses and resultReady rises MAN_W+3 cycles after the edge that samples startMul (26 at defaults), including special cases.
REQ-024 S_OUT: resultReady=1 and resultBus/flags stable until resultAccept=1 is sampled; the next cycle has resultReady=0 and the state is S_LDA.
REQ-025 Input with exponent 0 is treated as signed zero (denormals flushed).
REQ-026 NaN operand, or inf x zero -> canonical NaN: sign 0, exponent all ones, mantissa MSB only; flags 000.
REQ-027 inf x finite nonzero -> signed inf; zero x finite -> signed zero; flags 000.
REQ-028 Biased exponent >= 2^EXP_W-1 -> signed inf, overflow=1.
REQ-029 Biased exponent <= 0 -> signed zero, underflow=1.
REQ-030 inexact = guard OR sticky, for finite, non-overflow, non-underflow results only.

Reset
REQ-031 rst=1 at an edge -> state S_LDA, arm=1, A=B=0.
REQ-032 rst=1 at an edge -> resultBus=0, flags=0, dataAccept=0, doneMul=0, resultReady=0.
REQ-033 rst has priority over every other input in every state, including mid-S_MUL; no doneMul follows an aborted operation.

Verification
REQ-034 Load 0x41440000 then 0xC0600000, pulse startMul -> after 26 cycles doneMul pulses once, resultBus=0xC22B8000, flags=000, held until resultAccept.
REQ-035 After accept, load 0x40100000, 0x418C0000, start -> resultBus=0x421D8000, flags=000.
REQ-036 0x7F800000 x 0x00000000 -> 0x7FC00000; 0x7F000000 x 0x40000000 -> 0x7F800000, flags=100.
REQ-037 0x3FC00001 x 0x3FC00000: ROUND=0 -> 0x40100000, ROUND=1 -> 0x40100001; inexact=1 in both.
REQ-038 dataReady held high 3 cycles in S_LDA -> exactly one dataAccept pulse, only A loaded; startMul pulsed in S_LDB -> ignored.
REQ-039 rst pulsed 10 cycles into S_MUL -> all outputs 0, no doneMul; a fresh load and start then yields a correct product.
